// File: rtl/proc_io_resp_pkg.sv
// Shared constants and width helpers for the processor IO responder.
// A FIFO entry packs the output address above the data word.
package proc_io_resp_pkg;

    localparam int NUBITS_DEF = 16;
    localparam int NUIOIN_DEF = 8;
    localparam int NUIOOU_DEF = 8;
    localparam int ODEPTH_DEF = 4;

    // Address width for n items, never narrower than one bit.
    function automatic int io_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with occupancy count. Pushes are dropped when full,
// unless a pop in the same cycle makes room.
module io_fifo
    import proc_io_resp_pkg::*;
#(
    parameter int W     = 24,
    parameter int DEPTH = ODEPTH_DEF,
    parameter int AW    = io_aw(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] cnt_r;
    logic          do_pop_s;
    logic          do_push_s;

    assign full      = (cnt_r == CW'(DEPTH));
    assign empty     = (cnt_r == {CW{1'b0}});
    assign count     = cnt_r;
    assign pop_dat   = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Storage write; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_dat;
        end
    end

    // Pointer and occupancy tracking; power-of-2 depth wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/proc_io_resp.sv
// Peripheral-side responder for the processor IO bus: per-channel input
// holding registers for reads, shared {addr,data} FIFO for writes.
module proc_io_resp
    import proc_io_resp_pkg::*;
#(
    parameter int NUBITS = NUBITS_DEF,
    parameter int NUIOIN = NUIOIN_DEF,
    parameter int NUIOOU = NUIOOU_DEF,
    parameter int ODEPTH = ODEPTH_DEF,
    parameter int IAW    = io_aw(NUIOIN),
    parameter int OAW    = io_aw(NUIOOU)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [NUBITS-1:0]        io_in,
    input  logic [IAW-1:0]           addr_in,
    input  logic                     req_in,
    input  logic [NUBITS-1:0]        io_out,
    input  logic [OAW-1:0]           addr_out,
    input  logic                     out_en,
    input  logic [NUIOIN*NUBITS-1:0] ext_in_dat,
    input  logic [NUIOIN-1:0]        ext_in_vld,
    output logic [NUIOIN-1:0]        ext_in_rdy,
    output logic [NUBITS-1:0]        ext_out_dat,
    output logic [OAW-1:0]           ext_out_addr,
    output logic                     ext_out_vld,
    input  logic                     ext_out_rdy,
    output logic [NUIOIN-1:0]        in_udf,
    output logic                     out_ovf,
    output logic [$clog2(ODEPTH):0]  out_cnt
);

    localparam int EW = OAW + NUBITS;

    logic [NUBITS-1:0] hold_s [NUIOIN];
    logic [NUIOIN-1:0] full_s;
    logic [NUIOIN-1:0] udf_s;
    logic [NUIOIN-1:0] rd_sel_s;
    logic [EW-1:0]     head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              out_ovf_r;

    for (genvar gi = 0; gi < NUIOIN; gi++) begin : g_ch
        logic [NUBITS-1:0] hold_r;
        logic              full_r;
        logic              udf_r;

        assign rd_sel_s[gi] = req_in && (addr_in == IAW'(gi));
        assign hold_s[gi]   = hold_r;
        assign full_s[gi]   = full_r;
        assign udf_s[gi]    = udf_r;

        // Load only into an empty register, so a load never meets a pop here.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                hold_r <= {NUBITS{1'b0}};
                full_r <= 1'b0;
                udf_r  <= 1'b0;
            end else begin
                if (ext_in_vld[gi] && !full_r) begin
                    hold_r <= ext_in_dat[gi*NUBITS +: NUBITS];
                    full_r <= 1'b1;
                end else if (rd_sel_s[gi] && full_r) begin
                    full_r <= 1'b0;
                end
                if (rd_sel_s[gi] && !full_r) begin
                    udf_r <= 1'b1;
                end
            end
        end
    end

    assign ext_in_rdy = ~full_s;
    assign in_udf     = udf_s;

    // Zero-latency read mux; unpopulated channel addresses read as zero.
    always_comb begin
        io_in = {NUBITS{1'b0}};
        if (int'(addr_in) < NUIOIN) begin
            io_in = hold_s[addr_in];
        end else begin
            io_in = {NUBITS{1'b0}};
        end
    end

    io_fifo #(
        .W     (EW),
        .DEPTH (ODEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .push     (out_en),
        .push_dat ({addr_out, io_out}),
        .pop      (ext_out_rdy),
        .pop_dat  (head_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .count    (out_cnt)
    );

    assign ext_out_vld  = !fifo_empty_s;
    assign ext_out_addr = head_s[EW-1 -: OAW];
    assign ext_out_dat  = head_s[NUBITS-1:0];
    assign out_ovf      = out_ovf_r;

    // Sticky overflow: a full FIFO with a draining consumer still has room.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_ovf_r <= 1'b0;
        end else if (out_en && fifo_full_s && !ext_out_rdy) begin
            out_ovf_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_proc_io_resp.sv
// Randomised and directed bench for proc_io_resp against a queue/array
// reference model of the responder's read and write behaviour.
module tb_proc_io_resp;

    logic         clk;
    logic         rst;
    logic [15:0]  io_in;
    logic [2:0]   addr_in;
    logic         req_in;
    logic [15:0]  io_out;
    logic [2:0]   addr_out;
    logic         out_en;
    logic [127:0] ext_in_dat;
    logic [7:0]   ext_in_vld;
    logic [7:0]   ext_in_rdy;
    logic [15:0]  ext_out_dat;
    logic [2:0]   ext_out_addr;
    logic         ext_out_vld;
    logic         ext_out_rdy;
    logic [7:0]   in_udf;
    logic         out_ovf;
    logic [2:0]   out_cnt;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_hold [8];
    logic [7:0]  m_full;
    logic [7:0]  m_udf;
    logic        m_ovf;
    logic [18:0] m_q [$];

    proc_io_resp dut (
        .clk          (clk),
        .rst          (rst),
        .io_in        (io_in),
        .addr_in      (addr_in),
        .req_in       (req_in),
        .io_out       (io_out),
        .addr_out     (addr_out),
        .out_en       (out_en),
        .ext_in_dat   (ext_in_dat),
        .ext_in_vld   (ext_in_vld),
        .ext_in_rdy   (ext_in_rdy),
        .ext_out_dat  (ext_out_dat),
        .ext_out_addr (ext_out_addr),
        .ext_out_vld  (ext_out_vld),
        .ext_out_rdy  (ext_out_rdy),
        .in_udf       (in_udf),
        .out_ovf      (out_ovf),
        .out_cnt      (out_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not end (actual running, required finished)");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_hold[i] = 16'h0000;
        m_full = 8'h00;
        m_udf  = 8'h00;
        m_ovf  = 1'b0;
        m_q.delete();
    endtask

    task automatic idle();
        req_in      = 1'b0;
        addr_in     = 3'd0;
        io_out      = 16'h0000;
        addr_out    = 3'd0;
        out_en      = 1'b0;
        ext_in_dat  = 128'h0;
        ext_in_vld  = 8'h00;
        ext_out_rdy = 1'b0;
    endtask

    task automatic check_all();
        check_val("io_in", {16'h0, io_in}, {16'h0, m_hold[addr_in]});
        check_val("ext_in_rdy", {24'h0, ext_in_rdy}, {24'h0, ~m_full});
        check_val("in_udf", {24'h0, in_udf}, {24'h0, m_udf});
        check_val("out_ovf", {31'h0, out_ovf}, {31'h0, m_ovf});
        check_val("out_cnt", {29'h0, out_cnt}, m_q.size());
        check_val("ext_out_vld", {31'h0, ext_out_vld}, {31'h0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            check_val("ext_out_head", {13'h0, ext_out_addr, ext_out_dat}, {13'h0, m_q[0]});
        end
    endtask

    // Reference update from the pre-edge state and current inputs.
    task automatic model_update();
        logic [7:0] nf;
        logic       rd;
        logic       pop;
        logic       room;
        nf = m_full;
        for (int i = 0; i < 8; i++) begin
            rd = req_in && (addr_in == 3'(i));
            if (ext_in_vld[i] && !m_full[i]) begin
                m_hold[i] = ext_in_dat[i*16 +: 16];
                nf[i] = 1'b1;
            end else if (rd && m_full[i]) begin
                nf[i] = 1'b0;
            end
            if (rd && !m_full[i]) m_udf[i] = 1'b1;
        end
        m_full = nf;
        pop  = (m_q.size() != 0) && ext_out_rdy;
        room = (m_q.size() < 4) || pop;
        if (out_en && !room) m_ovf = 1'b1;
        if (pop) void'(m_q.pop_front());
        if (out_en && room) m_q.push_back({addr_out, io_out});
    endtask

    task automatic settle();
        #4;
        check_all();
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // reset then idle
        settle();
        check_val("rst_rdy", {24'h0, ext_in_rdy}, 32'h0000_00FF);
        check_val("rst_vld", {31'h0, ext_out_vld}, 32'h0);
        check_val("rst_io_in", {16'h0, io_in}, 32'h0);
        check_val("rst_dat", {16'h0, ext_out_dat}, 32'h0);
        advance();

        // load ch3 then read it
        ext_in_dat[3*16 +: 16] = 16'h1234;
        ext_in_vld = 8'h08;
        cyc();
        idle();
        settle();
        check_val("ld3_rdy", {31'h0, ext_in_rdy[3]}, 32'h0);
        advance();
        req_in = 1'b1;
        addr_in = 3'd3;
        settle();
        check_val("rd3_data", {16'h0, io_in}, 32'h0000_1234);
        advance();
        idle();
        settle();
        check_val("rd3_rdy", {24'h0, ext_in_rdy}, 32'h0000_00FF);
        check_val("rd3_udf", {24'h0, in_udf}, 32'h0);
        advance();

        // underrun on ch5, then a real load
        req_in = 1'b1;
        addr_in = 3'd5;
        settle();
        check_val("udf5_io", {16'h0, io_in}, 32'h0);
        advance();
        idle();
        settle();
        check_val("udf5_flag", {24'h0, in_udf}, 32'h0000_0020);
        advance();
        ext_in_dat[5*16 +: 16] = 16'hBEEF;
        ext_in_vld = 8'h20;
        cyc();
        idle();
        req_in = 1'b1;
        addr_in = 3'd5;
        settle();
        check_val("ld5_data", {16'h0, io_in}, 32'h0000_BEEF);
        check_val("ld5_udf", {24'h0, in_udf}, 32'h0000_0020);
        advance();
        idle();

        // five writes into a depth-4 FIFO with consumer stalled
        for (int k = 0; k < 5; k++) begin
            out_en = 1'b1;
            addr_out = 3'(k);
            io_out = 16'h0010 + 16'(k);
            cyc();
        end
        idle();
        settle();
        check_val("ovf_cnt", {29'h0, out_cnt}, 32'd4);
        check_val("ovf_flag", {31'h0, out_ovf}, 32'd1);
        advance();
        ext_out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check_val("drain_head", {13'h0, ext_out_addr, ext_out_dat}, {13'h0, 3'(k), 16'h0010 + 16'(k)});
            advance();
        end
        settle();
        check_val("drain_empty", {31'h0, ext_out_vld}, 32'd0);
        advance();
        idle();

        // two entries buffered, ch1 full, then asynchronous reset mid-cycle
        for (int k = 0; k < 2; k++) begin
            out_en = 1'b1;
            addr_out = 3'(k + 6);
            io_out = 16'hC000 + 16'(k);
            cyc();
        end
        idle();
        ext_in_dat[1*16 +: 16] = 16'h7777;
        ext_in_vld = 8'h02;
        cyc();
        idle();
        settle();
        check_val("pre_rst_cnt", {29'h0, out_cnt}, 32'd2);
        advance();
        #2;
        rst = 1'b0;
        #1;
        m_reset();
        check_all();
        check_val("arst_rdy", {24'h0, ext_in_rdy}, 32'h0000_00FF);
        check_val("arst_dat", {16'h0, ext_out_dat}, 32'h0);
        check_val("arst_ovf", {31'h0, out_ovf}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_en = 1'b1;
        addr_out = 3'd2;
        io_out = 16'h0055;
        settle();
        check_val("post_rst_vld0", {31'h0, ext_out_vld}, 32'd0);
        advance();
        idle();
        settle();
        check_val("post_rst_vld1", {31'h0, ext_out_vld}, 32'd1);
        check_val("post_rst_dat", {16'h0, ext_out_dat}, 32'h0000_0055);
        advance();

        // fill to 4, then push and pop together while full
        for (int k = 0; k < 3; k++) begin
            out_en = 1'b1;
            addr_out = 3'(k + 3);
            io_out = 16'hD000 + 16'(k);
            cyc();
        end
        out_en = 1'b1;
        addr_out = 3'd7;
        io_out = 16'hAAAA;
        ext_out_rdy = 1'b1;
        cyc();
        idle();
        settle();
        check_val("full_pp_cnt", {29'h0, out_cnt}, 32'd4);
        check_val("full_pp_ovf", {31'h0, out_ovf}, 32'd0);
        check_val("full_pp_head", {13'h0, ext_out_addr, ext_out_dat}, {13'h0, 3'd3, 16'hD000});
        advance();
        ext_out_rdy = 1'b1;
        repeat (4) cyc();
        idle();

        // randomised traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 8; i++) ext_in_dat[i*16 +: 16] = 16'($urandom);
            ext_in_vld  = 8'($urandom) & 8'($urandom);
            req_in      = 1'($urandom_range(0, 1));
            addr_in     = 3'($urandom_range(0, 7));
            out_en      = 1'($urandom_range(0, 1));
            addr_out    = 3'($urandom_range(0, 7));
            io_out      = 16'($urandom);
            ext_out_rdy = ($urandom_range(0, 3) != 0);
            cyc();
        end
        idle();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
